syscall_unit: RTL and testbench

//  Consumer end of the register file's v0/a0 service taps. When decode flags a SYSCALL, it samples v0 (service code) and a0 (argument).
//  It then executes print-int (signed decimal via iterative double-dabble), print-hex or halt.
//  It stalls the pipeline while converting. Drives the board display and the CPU halt line.

---
 rtl/syscall_unit.sv | 191 +++++++++++++++++++
 tb/tb_syscall_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/syscall_unit.sv
// syscall_unit: services SYSCALL requests using the v0/a0 register-file taps.
// print-int converts |a0| to 10 BCD digits with a 32-step double-dabble
// loop and stalls the pipeline while it runs. print-hex shows a0 directly.
// exit halts the CPU until reset. Unknown codes raise a sticky flag.
module syscall_unit #(
    parameter logic [31:0] SVC_PRINT_INT = 32'd1,
    parameter logic [31:0] SVC_PRINT_HEX = 32'd34,
    parameter logic [31:0] SVC_EXIT      = 32'd10,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             syscall,
    input  logic [31:0]      v0,
    input  logic [31:0]      a0,
    output logic             stall,
    output logic             halt,
    output logic [39:0]      disp_data,
    output logic             disp_neg,
    output logic             disp_hex,
    output logic             disp_valid,
    output logic             bad_svc,
    output logic [CNT_W-1:0] svc_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [31:0]        mag_r;
    logic [39:0]        bcd_r;
    logic               neg_r;
    logic [4:0]         step_r;
    logic               halt_r;
    logic [39:0]        disp_data_r;
    logic               disp_neg_r;
    logic               disp_hex_r;
    logic               disp_valid_r;
    logic               bad_svc_r;
    logic [CNT_W-1:0]   svc_count_r;

    logic               take_int_s;
    logic               take_hex_s;
    logic               take_exit_s;
    logic               take_bad_s;
    logic               stall_s;
    logic [71:0]        shifted_s;

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more,
    // so the following left shift carries correctly into the next digit.
    function automatic logic [39:0] bcd_adjust(input logic [39:0] bcd);
        logic [39:0] res;
        res = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

    // Request decode and the next conversion step of {bcd, mag}.
    always_comb begin
        take_int_s  = 1'b0;
        take_hex_s  = 1'b0;
        take_exit_s = 1'b0;
        take_bad_s  = 1'b0;
        if ((state_r == ST_IDLE) && syscall) begin
            if (v0 == SVC_PRINT_INT) begin
                take_int_s = 1'b1;
            end else if (v0 == SVC_PRINT_HEX) begin
                take_hex_s = 1'b1;
            end else if (v0 == SVC_EXIT) begin
                take_exit_s = 1'b1;
            end else begin
                take_bad_s = 1'b1;
            end
        end else begin
            take_int_s = 1'b0;
        end
        shifted_s = {bcd_adjust(bcd_r), mag_r} << 1;
    end

    // FSM next state and the combinational pipeline stall.
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (take_int_s) begin
                    state_nxt_s = ST_CONV;
                    stall_s     = 1'b1;
                end else if (take_exit_s) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                stall_s = 1'b1;
                if (step_r == 5'd31) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CONV;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Conversion datapath, display registers, flags and the service counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_r        <= 32'd0;
            bcd_r        <= 40'd0;
            neg_r        <= 1'b0;
            step_r       <= 5'd0;
            halt_r       <= 1'b0;
            disp_data_r  <= 40'd0;
            disp_neg_r   <= 1'b0;
            disp_hex_r   <= 1'b0;
            disp_valid_r <= 1'b0;
            bad_svc_r    <= 1'b0;
            svc_count_r  <= {CNT_W{1'b0}};
        end else begin
            disp_valid_r <= 1'b0;
            if (take_int_s) begin
                mag_r       <= a0[31] ? (~a0 + 32'd1) : a0;
                neg_r       <= a0[31];
                bcd_r       <= 40'd0;
                step_r      <= 5'd0;
                svc_count_r <= svc_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (take_hex_s) begin
                disp_data_r  <= {8'h00, a0};
                disp_hex_r   <= 1'b1;
                disp_neg_r   <= 1'b0;
                disp_valid_r <= 1'b1;
                svc_count_r  <= svc_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (take_exit_s) begin
                halt_r      <= 1'b1;
                svc_count_r <= svc_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (take_bad_s) begin
                bad_svc_r <= 1'b1;
            end else if (state_r == ST_CONV) begin
                bcd_r  <= shifted_s[71:32];
                mag_r  <= shifted_s[31:0];
                step_r <= step_r + 5'd1;
                if (step_r == 5'd31) begin
                    disp_data_r  <= shifted_s[71:32];
                    disp_neg_r   <= neg_r;
                    disp_hex_r   <= 1'b0;
                    disp_valid_r <= 1'b1;
                end else begin
                    disp_valid_r <= 1'b0;
                end
            end else begin
                disp_valid_r <= 1'b0;
            end
        end
    end

    assign stall      = stall_s;
    assign halt       = halt_r;
    assign disp_data  = disp_data_r;
    assign disp_neg   = disp_neg_r;
    assign disp_hex   = disp_hex_r;
    assign disp_valid = disp_valid_r;
    assign bad_svc    = bad_svc_r;
    assign svc_count  = svc_count_r;

endmodule

// File: tb/tb_syscall_unit.sv
// Directed + randomized bench for syscall_unit with a decimal reference model.
module tb_syscall_unit;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          syscall;
    logic [31:0]   v0;
    logic [31:0]   a0;
    logic          stall;
    logic          halt;
    logic [39:0]   disp_data;
    logic          disp_neg;
    logic          disp_hex;
    logic          disp_valid;
    logic          bad_svc;
    logic [CW-1:0] svc_count;

    int errors = 0;
    int checks = 0;

    // model state
    int          m_count;
    logic [39:0] m_data;
    logic        m_neg;
    logic        m_hex;
    logic        m_bad;
    logic        m_halt;

    syscall_unit #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .syscall(syscall), .v0(v0), .a0(a0),
        .stall(stall), .halt(halt), .disp_data(disp_data), .disp_neg(disp_neg),
        .disp_hex(disp_hex), .disp_valid(disp_valid), .bad_svc(bad_svc),
        .svc_count(svc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal digits of |x| by repeated division, packed as BCD.
    function automatic logic [39:0] ref_bcd(input logic [31:0] x);
        longint      v;
        logic [39:0] r;
        v = longint'($signed(x));
        if (v < 0) v = -v;
        r = 40'd0;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".halt"},  64'(halt),      64'(m_halt));
        chk({tag, ".data"},  64'(disp_data), 64'(m_data));
        chk({tag, ".neg"},   64'(disp_neg),  64'(m_neg));
        chk({tag, ".hex"},   64'(disp_hex),  64'(m_hex));
        chk({tag, ".bad"},   64'(bad_svc),   64'(m_bad));
        chk({tag, ".count"}, 64'(svc_count), 64'(m_count % (1 << CW)));
    endtask

    task automatic model_reset();
        m_count = 0; m_data = 40'd0; m_neg = 1'b0; m_hex = 1'b0;
        m_bad = 1'b0; m_halt = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; syscall = 1'b0;
        @(negedge clk);
        model_reset();
        chk("rst.stall", 64'(stall), 64'd0);
        chk("rst.valid", 64'(disp_valid), 64'd0);
        check_state("rst");
        rst = 1'b0;
    endtask

    // print-int; optionally keeps issuing a hex request during conversion
    task automatic print_int(input logic [31:0] val, input bit disturb);
        int n;
        int early;
        @(negedge clk);
        syscall = 1'b1; v0 = 32'd1; a0 = val;
        #1;
        chk("int.req_stall", 64'(stall), 64'd1);
        @(negedge clk);
        syscall = disturb; v0 = 32'd34; a0 = $urandom;
        n = 1; early = 0;
        while (stall && n < 100) begin
            if (disp_valid) early++;
            n++;
            @(negedge clk);
        end
        syscall = 1'b0;
        m_count++;
        m_data = ref_bcd(val); m_neg = val[31]; m_hex = 1'b0;
        chk("int.stall_cycles", 64'(n), 64'd33);
        chk("int.early_valid", 64'(early), 64'd0);
        chk("int.valid", 64'(disp_valid), 64'd1);
        check_state("int");
        @(negedge clk);
        chk("int.valid_drop", 64'(disp_valid), 64'd0);
        chk("int.hold", 64'(disp_data), 64'(m_data));
    endtask

    task automatic print_hex(input logic [31:0] val);
        @(negedge clk);
        syscall = 1'b1; v0 = 32'd34; a0 = val;
        #1;
        chk("hex.stall", 64'(stall), 64'd0);
        @(negedge clk);
        syscall = 1'b0;
        m_count++;
        m_data = {8'h00, val}; m_neg = 1'b0; m_hex = 1'b1;
        chk("hex.valid", 64'(disp_valid), 64'd1);
        check_state("hex");
        @(negedge clk);
        chk("hex.valid_drop", 64'(disp_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1; syscall = 1'b0; v0 = 32'd0; a0 = 32'd0;
        model_reset();
        do_reset();

        print_int(32'd1234, 1'b0);
        chk("int1234", 64'(disp_data), 64'h0000001234);
        print_int(-32'sd7, 1'b1);
        chk("int_m7", 64'(disp_data), 64'h0000000007);
        print_int(32'h80000000, 1'b0);
        chk("int_min", 64'(disp_data), 64'h2147483648);
        print_int(32'd0, 1'b1);
        print_int(32'h7FFFFFFF, 1'b0);
        print_hex(32'hDEADBEEF);
        chk("hex_dead", 64'(disp_data), 64'h00DEADBEEF);

        for (int i = 0; i < 4; i++) begin
            print_int($urandom, i[0]);
            print_hex($urandom);
        end

        // unknown service code
        @(negedge clk);
        syscall = 1'b1; v0 = 32'd5; a0 = $urandom;
        #1;
        chk("bad.stall", 64'(stall), 64'd0);
        @(negedge clk);
        syscall = 1'b0;
        m_bad = 1'b1;
        chk("bad.valid", 64'(disp_valid), 64'd0);
        check_state("bad");

        // reset in the middle of a conversion
        @(negedge clk);
        syscall = 1'b1; v0 = 32'd1; a0 = 32'd999;
        @(negedge clk);
        syscall = 1'b0;
        repeat (15) @(negedge clk);
        chk("mid.stall", 64'(stall), 64'd1);
        do_reset();
        repeat (40) begin
            @(negedge clk);
            if (disp_valid || stall) break;
        end
        chk("mid.no_result", 64'(disp_valid), 64'd0);
        chk("mid.idle", 64'(stall), 64'd0);

        // counter wrap
        for (int i = 0; i < (1 << CW); i++) begin
            print_int($urandom, 1'b0);
        end
        chk("wrap.count", 64'(svc_count), 64'd0);

        // exit, then further syscalls ignored
        @(negedge clk);
        syscall = 1'b1; v0 = 32'd10; a0 = 32'd0;
        #1;
        chk("exit.stall", 64'(stall), 64'd0);
        @(negedge clk);
        m_count++; m_halt = 1'b1;
        v0 = 32'd1; a0 = 32'd55;
        #1;
        chk("halt.stall", 64'(stall), 64'd0);
        repeat (5) @(negedge clk);
        syscall = 1'b0;
        chk("halt.valid", 64'(disp_valid), 64'd0);
        check_state("halt");
        chk("halt.count1", 64'(svc_count), 64'd1);

        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
